// File: rtl/serial_frame_checker.sv
// -----------------------------------------------------------------------------
// serial_frame_checker
//   Receives a serial frame one bit per enabled clock edge:
//     start(0), DATA_W data bits LSB-first, parity bit, stop(1).
//   Tracks the running data parity, flags each completed frame as good or bad,
//   latches the payload of the last good frame and keeps saturating counters
//   of good and bad frames. The bit strobe (en) normally comes from an
//   external bit-rate strobe generator.
//
// Parameters
//   DATA_W   data bits per frame (1..32)
//   ODD_PAR  0 = even parity, 1 = odd parity
//   CNT_W    width of the good/bad frame counters
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   en     in   1        bit strobe; i is sampled only on edges with en=1
//   i      in   1        serial data, idle line = 1
//   clr    in   1        synchronous clear of c and e (wins over increment)
//   p      out  1        running XOR of the data bits of the current frame
//   g      out  1        one-cycle pulse: frame good
//   b      out  1        one-cycle pulse: frame bad (parity or stop error)
//   data   out  DATA_W   payload of the last good frame
//   c      out  CNT_W    good-frame count, saturating
//   e      out  CNT_W    bad-frame count, saturating
//   busy   out  1        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_frame_checker #(
  parameter int DATA_W  = 8,
  parameter int ODD_PAR = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i,
  input  logic              clr,
  output logic              p,
  output logic              g,
  output logic              b,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  c,
  output logic [CNT_W-1:0]  e,
  output logic              busy
);

  // Bit counter only needs to reach DATA_W-1; keep it at least one bit wide.
  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DATA_W - 1);
  localparam logic              PAR_SENSE = (ODD_PAR != 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t             state_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  shift_next;
  logic [BCNT_W-1:0]  bit_cnt_reg;
  logic               pb_reg;
  logic               frame_good;
  logic               frame_done;

  // LSB-first: each new bit enters at the top and moves down, so after
  // DATA_W bits the first received bit sits in bit 0. Written this way so
  // that DATA_W=1 needs no special case.
  always_comb begin
    shift_next             = shift_reg >> 1;
    shift_next[DATA_W-1]   = i;
  end

  // Evaluated while sampling the stop bit: i is the stop bit here.
  assign frame_good = (pb_reg == (p ^ PAR_SENSE)) && i;
  assign frame_done = en && (state_reg == S_STOP);

  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      pb_reg      <= 1'b0;
      p           <= 1'b0;
      g           <= 1'b0;
      b           <= 1'b0;
      data        <= '0;
      c           <= '0;
      e           <= '0;
    end else begin
      // Result pulses last exactly one cycle regardless of en.
      g <= 1'b0;
      b <= 1'b0;

      if (en) begin
        case (state_reg)
          S_IDLE: begin
            if (!i) begin
              state_reg   <= S_DATA;
              bit_cnt_reg <= '0;
              p           <= 1'b0;
            end
          end
          S_DATA: begin
            shift_reg   <= shift_next;
            p           <= p ^ i;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= S_PAR;
            end
          end
          S_PAR: begin
            pb_reg    <= i;
            state_reg <= S_STOP;
          end
          S_STOP: begin
            // Returning straight to idle lets a start bit follow on the
            // very next enabled edge.
            state_reg <= S_IDLE;
            if (frame_good) begin
              g    <= 1'b1;
              data <= shift_reg;
            end else begin
              b <= 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end

      // Counters: clear wins over an increment on the same edge.
      if (clr) begin
        c <= '0;
        e <= '0;
      end else if (frame_done) begin
        if (frame_good && (c != CNT_MAX)) begin
          c <= c + 1'b1;
        end
        if (!frame_good && (e != CNT_MAX)) begin
          e <= e + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_checker.sv
module tb_serial_frame_checker;

  logic clk = 1'b0;
  logic rst_n, en, i, clr;

  // dut0: defaults; dut1: CNT_W=2; dut2: ODD_PAR=1. All share the inputs.
  logic       p0, g0, b0, busy0;
  logic [7:0] data0, c0, e0;
  logic       p1, g1, b1, busy1;
  logic [7:0] data1;
  logic [1:0] c1, e1;
  logic       p2, g2, b2, busy2;
  logic [7:0] data2, c2, e2;

  always #5 clk = ~clk;

  serial_frame_checker #(.DATA_W(8), .ODD_PAR(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i), .clr(clr),
    .p(p0), .g(g0), .b(b0), .data(data0), .c(c0), .e(e0), .busy(busy0)
  );

  serial_frame_checker #(.DATA_W(8), .ODD_PAR(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i), .clr(clr),
    .p(p1), .g(g1), .b(b1), .data(data1), .c(c1), .e(e1), .busy(busy1)
  );

  serial_frame_checker #(.DATA_W(8), .ODD_PAR(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i), .clr(clr),
    .p(p2), .g(g2), .b(b2), .data(data2), .c(c2), .e(e2), .busy(busy2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One enabled bit, then 'gap' disabled cycles with a randomly wiggling line.
  task automatic drive_bit(input logic bv, input int gap, input logic cl);
    en  = 1'b1;
    i   = bv;
    clr = cl;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    repeat (gap) begin
      i = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Full frame; on return we are 1 time unit after the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                            input int gap, input logic clr_at_stop);
    drive_bit(1'b0, gap, 1'b0);
    check("busy_after_start", busy0, 1);
    for (int k = 0; k < 8; k++) drive_bit(d[k], gap, 1'b0);
    drive_bit(pb, gap, 1'b0);
    drive_bit(sb, 0, clr_at_stop);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    int         gap;
    logic       b2b;        // next frame follows with no idle cycle
    logic       good_even;  // hand-computed result, even parity
    logic       good_odd;   // hand-computed result, odd parity
    logic       par;        // hand-computed XOR of data bits
  } vec_t;

  vec_t vecs[9];

  logic [7:0] m_data0, m_c0, m_e0;
  logic [1:0] m_c1;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    en    = 1'b0;
    i     = 1'b1;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p", p0, 0);
    check("rst_g", g0, 0);
    check("rst_b", b0, 0);
    check("rst_data", data0, 0);
    check("rst_c", c0, 0);
    check("rst_e", e0, 0);
    check("rst_busy", busy0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    m_data0 = 8'h00;
    m_c0    = 8'd0;
    m_e0    = 8'd0;
    m_c1    = 2'd0;

    for (int n = 0; n < 9; n++) begin
      send_frame(vecs[n].d, vecs[n].pb, vecs[n].sb, vecs[n].gap, 1'b0);
      if (vecs[n].good_even) begin
        m_data0 = vecs[n].d;
        if (m_c0 != 8'hFF) m_c0 = m_c0 + 8'd1;
        if (m_c1 != 2'd3)  m_c1 = m_c1 + 2'd1;
      end else begin
        if (m_e0 != 8'hFF) m_e0 = m_e0 + 8'd1;
      end
      $display("frame %0d data=%02h pb=%0b sb=%0b gap=%0d -> g=%0b b=%0b data=%02h c=%0d e=%0d c2bit=%0d odd_g=%0b",
               n, vecs[n].d, vecs[n].pb, vecs[n].sb, vecs[n].gap, g0, b0, data0, c0, e0, c1, g2);
      check("g", g0, vecs[n].good_even);
      check("b", b0, !vecs[n].good_even);
      check("data", data0, m_data0);
      check("c", c0, m_c0);
      check("e", e0, m_e0);
      check("p_final", p0, vecs[n].par);
      check("busy_end", busy0, 0);
      check("c_sat2", c1, m_c1);
      check("odd_g", g2, vecs[n].good_odd);
      check("odd_b", b2, !vecs[n].good_odd);
      if (!vecs[n].b2b) begin
        @(posedge clk);
        #1;
        check("g_width", g0, 0);
        check("b_width", b0, 0);
        check("p_hold", p0, vecs[n].par);
      end
    end

    // Clear on the same edge that raises the good pulse.
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    $display("clr frame data=a5 -> g=%0b data=%02h c=%0d e=%0d c2bit=%0d", g0, data0, c0, e0, c1);
    check("clr_g", g0, 1);
    check("clr_data", data0, 8'hA5);
    check("clr_c", c0, 0);
    check("clr_e", e0, 0);
    check("clr_c2bit", c1, 0);

    // Asynchronous reset after four data bits of 0x07 (p=1 at that point).
    drive_bit(1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(((k < 3) ? 1'b1 : 1'b0), 0, 1'b0);
    check("pre_rst_p", p0, 1);
    check("pre_rst_busy", busy0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-frame -> busy=%0b p=%0b data=%02h c=%0d e=%0d", busy0, p0, data0, c0, e0);
    check("arst_busy", busy0, 0);
    check("arst_p", p0, 0);
    check("arst_data", data0, 0);
    check("arst_c", c0, 0);
    check("arst_e", e0, 0);
    check("arst_g", g0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    $display("post-reset frame data=3c -> g=%0b b=%0b data=%02h c=%0d e=%0d", g0, b0, data0, c0, e0);
    check("post_g", g0, 1);
    check("post_b", b0, 0);
    check("post_data", data0, 8'h3C);
    check("post_c", c0, 1);
    check("post_e", e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
